// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 bit mux through its enabled channels with a programmable settle
// time, assembles a 4-bit frame and hands it off over valid/ready. Optional MUX_SCAN_PARITY_EN adds frame_par.
module mux_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [3:0]         ch_mask,
    input  logic               mux_in,
    output logic [1:0]         sel,
    output logic [3:0]         frame,
    output logic               frame_valid,
    input  logic               frame_ready,
    output logic               busy,
    output logic               overrun
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic               frame_par
`endif
);

    typedef enum logic {IDLE, SETTLE} state_t;

    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

    state_t             state_reg, state_next;
    logic [DWELL_W-1:0] dwell_q, dwell_q_next;
    logic [3:0]         mask_q, mask_q_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [1:0]         sel_reg, sel_next;
    logic [3:0]         shadow_reg, shadow_next;
    logic [3:0]         frame_reg, frame_next;
    logic               valid_reg, valid_next;
    logic               overrun_reg, overrun_next;
    logic               par_reg, par_next;
    logic [3:0]         above;
    logic [3:0]         candidate;
    logic               load;

    // Lowest set bit of a channel mask; callers guarantee the mask is non-zero.
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Enabled channels strictly above the current one; empty means this slot ends the scan.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_above
            localparam logic [1:0] CH = 2'(gi);
            assign above[gi] = mask_q[gi] && (CH > sel_reg);
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        dwell_q_next = dwell_q;
        mask_q_next  = mask_q;
        cnt_next     = cnt_reg;
        sel_next     = sel_reg;
        shadow_next  = shadow_reg;
        frame_next   = frame_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;
        par_next     = par_reg;
        load         = 1'b0;
        candidate    = shadow_reg;
        candidate[sel_reg] = mux_in;

        if (valid_reg && frame_ready) valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start && (ch_mask != 4'd0)) begin
                    state_next   = SETTLE;
                    dwell_q_next = dwell;
                    mask_q_next  = ch_mask;
                    sel_next     = lowest_ch(ch_mask);
                    cnt_next     = '0;
                    shadow_next  = 4'd0;
                    overrun_next = 1'b0;
                end
            end
            SETTLE: begin
                if (cnt_reg == dwell_q) begin
                    cnt_next = '0;
                    shadow_next[sel_reg] = mux_in;
                    if (above != 4'd0) begin
                        sel_next = lowest_ch(above);
                    end else begin
                        load = !valid_reg || frame_ready;
                        if (load) begin
                            frame_next = candidate;
                            valid_next = 1'b1;
                            par_next   = ^candidate;
                        end else begin
                            overrun_next = 1'b1;
                        end
                        if (cont) begin
                            sel_next    = lowest_ch(mask_q);
                            shadow_next = 4'd0;
                        end else begin
                            state_next = IDLE;
                            sel_next   = 2'd0;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            dwell_q     <= '0;
            mask_q      <= 4'd0;
            cnt_reg     <= '0;
            sel_reg     <= 2'd0;
            shadow_reg  <= 4'd0;
            frame_reg   <= 4'd0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            par_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            dwell_q     <= dwell_q_next;
            mask_q      <= mask_q_next;
            cnt_reg     <= cnt_next;
            sel_reg     <= sel_next;
            shadow_reg  <= shadow_next;
            frame_reg   <= frame_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
            par_reg     <= par_next;
        end
    end

    assign sel         = sel_reg;
    assign frame       = frame_reg;
    assign frame_valid = valid_reg;
    assign busy        = (state_reg != IDLE);
    assign overrun     = overrun_reg;

`ifdef MUX_SCAN_PARITY_EN
    assign frame_par = par_reg;
`else
    logic unused_par;
    assign unused_par = par_reg;
`endif

endmodule
